ctrl_mc: RTL
============

CTRL_MC -- requirements
Module: ctrl_mc

Interface
REQ-001 SHALL have parameter RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL have parameter TRAP_PC, 32'h0000_0010, PC loaded on illegal instruction (CTRL_MC_ILLEGAL_TRAP_EN only).
REQ-003 SHALL have parameter MEM_WAIT_MAX, 0, maximum mem_ready wait in cycles; 0 = unbounded.
REQ-004 SHALL have ports: clk in 1 clock; rst in 1 reset. One clock; reset is synchronous and active-high.
REQ-005 SHALL have ports: mem_req out 1 access request; mem_wen out 1 write; mem_mode out 3 funct3 size code; mem_addr out 32 byte address; mem_rdata in 32 read data; mem_ready in 1 access complete.
REQ-006 SHALL have ports: reg_wen out 1; regA_sel/regB_sel/regW_sel out 5 each; alu_ctrl out 4; alu_zero in 1; alu_res in 32; regA in 32; imm out 32; imm_sel out 1 (ALU B = imm); pc_sel out 1 (ALU A = pc).
REQ-007 SHALL have ports: wb_sel out 2 (00 ALU, 01 mem_rdata, 10 pc+4); pc out 32 current PC; retire out 1 one-cycle pulse per completed instruction; illegal out 1 one-cycle pulse.

Function
REQ-008 SHALL sequence states FETCH, DECODE, EXEC, MEM, WB (plus TRAP when enabled); one state per cycle except MEM-handshake waits.
REQ-009 FETCH SHALL assert mem_req=1, mem_wen=0, mem_mode=3'b010, mem_addr=pc; on mem_ready latch mem_rdata into instruction register (IR), go DECODE.
REQ-010 mem_req, mem_wen, mem_mode, mem_addr SHALL stay stable while mem_req=1 and mem_ready=0; mem_ready SHALL be ignored when mem_req=0.
REQ-011 DECODE SHALL drive regX_sel from IR[19:15]/[24:20]/[11:7] and imm per format (I, S, B, U, J) sign-extended; selects held from DECODE through WB.
REQ-012 EXEC alu_ctrl: R {f7[5],f3}; I {f7[5]&(f3==101),f3}; LOAD/STORE/AUIPC/JAL/JALR 0000; LUI 1111; BEQ/BNE 1000; BLT/BGE 0010; BLTU/BGEU 0011.
REQ-013 Branch in EXEC: taken when (BEQ,BGE,BGEU and alu_zero) or (BNE,BLT,BLTU and !alu_zero); pc <= taken ? pc+immB : pc+4; retire; go FETCH. All six branch types SHALL update pc.
REQ-014 JAL: pc <= pc+immJ; JALR: pc <= (regA+immI)&~1; both write pc+4 to rd via wb_sel=10 in WB.
REQ-015 LOAD/STORE: EXEC computes address; MEM asserts mem_req, mem_addr=alu_res (registered), mem_mode=funct3, mem_wen=STORE; LOAD latches mem_rdata into data register on mem_ready then WB (wb_sel=01); STORE retires from MEM on mem_ready.
REQ-016 WB SHALL assert reg_wen for exactly one cycle; reg_wen SHALL be 0 when regW_sel=0 and in every other state.
REQ-017 Non-branch/non-jump instructions SHALL set pc <= pc+4 in WB (or MEM for STORE); PC changes exactly once per instruction.
REQ-018 Latency (mem_ready same cycle): branch 3, ALU/LUI/AUIPC/JAL/JALR 4, STORE 4, LOAD 5 cycles; each extra wait cycle adds one.
REQ-019 MEM_WAIT_MAX>0: wait counter reaching MEM_WAIT_MAX SHALL drop mem_req, treat as illegal (REQ-022), counter cleared on every new request.
REQ-020 retire SHALL pulse in the cycle pc is updated; never during waits.

Reset
REQ-021 rst SHALL take priority over all state: state FETCH, pc=RESET_PC, IR=0, counter=0, mem_req=0, mem_wen=0, reg_wen=0, retire=0, illegal=0; reset mid-MEM aborts access without write.

Configuration
REQ-022 Macro CTRL_MC_ILLEGAL_TRAP_EN defined: undefined opcode, or JAL/JALR/taken-branch target with bits[1:0]!=0, enters TRAP for one cycle: illegal=1, pc <= TRAP_PC, no reg/mem write, then FETCH. Undefined: undefined opcode executes as NOP (pc+4, retire), targets not checked, illegal tied 0, TRAP absent.

Verification
REQ-023 ADDI x1,x0,5 (0x00500093), mem_ready immediate -> reg_wen 1 cycle at cycle 4, regW_sel=1, imm=5, pc 0->4, one retire.
REQ-024 BGEU x0,x0,+8 with alu_zero=1 at pc=0x20 -> pc=0x28 after 3 cycles, reg_wen never asserted.
REQ-025 LW x2,4(x1) with mem_ready delayed 3 cycles in MEM -> mem_addr/mem_mode=010 stable during wait, wb_sel=01, total 8 cycles.
REQ-026 SW with rst asserted in MEM -> mem_req=0 next cycle, pc=RESET_PC, no reg_wen.
REQ-027 Opcode 7'h7F, macro defined -> illegal pulse, pc=TRAP_PC=0x10; macro undefined -> pc+4, illegal 0.

Source files
------------

// File: rtl/ctrl_mc_if.sv
// ctrl_mc_if -- memory bus between the multi-cycle controller and memory.
//
// The controller (master) drives a request with write flag, funct3 size code
// and byte address; memory (slave) returns read data and a completion strobe.
//   mem_req   : access request, held until mem_ready
//   mem_wen   : 1 = write access
//   mem_mode  : funct3 size code (3'b010 for instruction fetch)
//   mem_addr  : byte address
//   mem_rdata : read data, valid with mem_ready
//   mem_ready : access complete (ignored while mem_req = 0)
interface ctrl_mc_if;
  logic        mem_req;
  logic        mem_wen;
  logic [2:0]  mem_mode;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  modport master (
    output mem_req, mem_wen, mem_mode, mem_addr,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_req, mem_wen, mem_mode, mem_addr,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/ctrl_mc.sv
// ctrl_mc -- multi-cycle RV32I control unit.
//
// Sequences FETCH -> DECODE -> EXEC -> [MEM] -> [WB] -> FETCH and drives the
// register file, ALU and memory-bus controls of an external datapath.
//
// Parameters:
//   RESET_PC     : PC after reset
//   TRAP_PC      : PC loaded on an illegal instruction (trap build only)
//   MEM_WAIT_MAX : max cycles waiting for mem_ready, 0 = unbounded
//
// Build option: define CTRL_MC_ILLEGAL_TRAP_EN to trap undefined opcodes and
// misaligned jump/taken-branch targets to TRAP_PC (one TRAP cycle, illegal=1).
// Without it undefined opcodes retire as NOPs and targets are not checked.
//
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   mem             : memory bus (ctrl_mc_if master)
//   reg_wen         : register write enable (WB only, never for x0)
//   regA/B/W_sel    : register selects from IR, held DECODE..WB
//   alu_ctrl        : ALU operation; alu_zero/alu_res come back from the ALU
//   regA            : value of rs1 (used for the JALR target)
//   imm, imm_sel    : sign-extended immediate, ALU B = imm
//   pc_sel          : ALU A = pc
//   wb_sel          : 00 ALU, 01 mem_rdata, 10 pc+4
//   pc              : current PC
//   retire, illegal : one-cycle pulses per completed / trapped instruction
module ctrl_mc #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter logic [31:0] TRAP_PC      = 32'h0000_0010,
  parameter int unsigned MEM_WAIT_MAX = 0
) (
  input  logic        clk,
  input  logic        rst,
  ctrl_mc_if.master   mem,
  output logic        reg_wen,
  output logic [4:0]  regA_sel,
  output logic [4:0]  regB_sel,
  output logic [4:0]  regW_sel,
  output logic [3:0]  alu_ctrl,
  input  logic        alu_zero,
  input  logic [31:0] alu_res,
  input  logic [31:0] regA,
  output logic [31:0] imm,
  output logic        imm_sel,
  output logic        pc_sel,
  output logic [1:0]  wb_sel,
  output logic [31:0] pc,
  output logic        retire,
  output logic        illegal
);

`ifdef CTRL_MC_ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // ST_TRAP is only ever entered when TRAP_EN is set.
  typedef enum logic [2:0] {
    ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_TRAP
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] ir_reg, ir_next;
  logic [31:0] addr_reg, addr_next;
  logic [31:0] wait_cnt_reg, wait_cnt_next;
  logic        active_reg;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        is_r, is_imm, is_load, is_store, is_branch;
  logic        is_jal, is_jalr, is_lui, is_auipc, known_op;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] pc_plus4, br_tgt, jal_tgt, jalr_sum, jalr_tgt;
  logic        br_taken, tgt_misaligned;
  logic        mem_state, req_raw, handshake, timeout;
  logic        retire_c, illegal_c, reg_wen_c, take_fault;

  // ---------------------------------------------------------------- decode
  assign opcode    = ir_reg[6:0];
  assign funct3    = ir_reg[14:12];
  assign is_r      = (opcode == OP_R);
  assign is_imm    = (opcode == OP_IMM);
  assign is_load   = (opcode == OP_LOAD);
  assign is_store  = (opcode == OP_STORE);
  assign is_branch = (opcode == OP_BRANCH);
  assign is_jal    = (opcode == OP_JAL);
  assign is_jalr   = (opcode == OP_JALR);
  assign is_lui    = (opcode == OP_LUI);
  assign is_auipc  = (opcode == OP_AUIPC);
  assign known_op  = is_r | is_imm | is_load | is_store | is_branch |
                     is_jal | is_jalr | is_lui | is_auipc;

  assign imm_i = {{20{ir_reg[31]}}, ir_reg[31:20]};
  assign imm_s = {{20{ir_reg[31]}}, ir_reg[31:25], ir_reg[11:7]};
  assign imm_b = {{19{ir_reg[31]}}, ir_reg[31], ir_reg[7], ir_reg[30:25],
                  ir_reg[11:8], 1'b0};
  assign imm_u = {ir_reg[31:12], 12'h000};
  assign imm_j = {{11{ir_reg[31]}}, ir_reg[31], ir_reg[19:12], ir_reg[20],
                  ir_reg[30:21], 1'b0};

  assign regA_sel = ir_reg[19:15];
  assign regB_sel = ir_reg[24:20];
  assign regW_sel = ir_reg[11:7];
  assign pc       = pc_reg;

  // Datapath controls come straight from IR so they stay stable from
  // DECODE through WB (the ALU result is still consumed in WB).
  always_comb begin
    imm      = 32'h0;
    imm_sel  = 1'b0;
    pc_sel   = 1'b0;
    wb_sel   = 2'b00;
    alu_ctrl = 4'b0000;
    if (is_imm || is_load || is_jalr) imm = imm_i;
    else if (is_store)                imm = imm_s;
    else if (is_branch)               imm = imm_b;
    else if (is_lui || is_auipc)      imm = imm_u;
    else if (is_jal)                  imm = imm_j;
    imm_sel = is_imm | is_load | is_store | is_lui | is_auipc | is_jalr;
    pc_sel  = is_auipc;
    if (is_load)               wb_sel = 2'b01;
    else if (is_jal || is_jalr) wb_sel = 2'b10;
    if (is_r)        alu_ctrl = {ir_reg[30], funct3};
    else if (is_imm) alu_ctrl = {ir_reg[30] & (funct3 == 3'b101), funct3};
    else if (is_lui) alu_ctrl = 4'b1111;
    else if (is_branch) begin
      case (funct3[2:1])
        2'b10:   alu_ctrl = 4'b0010;  // BLT/BGE: signed less-than
        2'b11:   alu_ctrl = 4'b0011;  // BLTU/BGEU: unsigned less-than
        default: alu_ctrl = 4'b1000;  // BEQ/BNE: subtract
      endcase
    end
  end

  // The ALU reports zero for "equal" or for "not less than", so BEQ/BGE/BGEU
  // branch on zero and BNE/BLT/BLTU on non-zero.
  always_comb begin
    case (funct3)
      3'b000, 3'b101, 3'b111: br_taken = alu_zero;
      3'b001, 3'b100, 3'b110: br_taken = ~alu_zero;
      default:                br_taken = 1'b0;
    endcase
  end

  assign pc_plus4 = pc_reg + 32'd4;
  assign br_tgt   = pc_reg + imm_b;
  assign jal_tgt  = pc_reg + imm_j;
  assign jalr_sum = regA + imm_i;
  assign jalr_tgt = jalr_sum & ~32'd1;

  assign tgt_misaligned = TRAP_EN &&
                          ((is_branch && br_taken && (br_tgt[1:0] != 2'b00)) ||
                           (is_jal  && (jal_tgt[1:0]  != 2'b00)) ||
                           (is_jalr && (jalr_tgt[1:0] != 2'b00)));

  // ------------------------------------------------------------ memory bus
  // active_reg keeps the first cycle after reset idle so mem_req comes out
  // of reset low.
  assign mem_state = (state_reg == ST_FETCH) || (state_reg == ST_MEM);
  assign timeout   = mem_state && active_reg && (MEM_WAIT_MAX != 0) &&
                     (wait_cnt_reg == MEM_WAIT_MAX);
  assign req_raw   = mem_state && active_reg && !timeout;
  assign handshake = req_raw && mem.mem_ready;

  // rst gates the strobes combinationally so an access in flight is dropped
  // in the reset cycle itself, before the memory can complete a write.
  assign mem.mem_req  = req_raw & ~rst;
  assign mem.mem_wen  = req_raw & ~rst & (state_reg == ST_MEM) & is_store;
  assign mem.mem_mode = (state_reg == ST_MEM) ? funct3 : 3'b010;
  assign mem.mem_addr = (state_reg == ST_MEM) ? addr_reg : pc_reg;

  // ------------------------------------------------------------------- FSM
  always_comb begin
    state_next    = state_reg;
    pc_next       = pc_reg;
    ir_next       = ir_reg;
    addr_next     = addr_reg;
    wait_cnt_next = 32'h0;
    retire_c      = 1'b0;
    illegal_c     = 1'b0;
    reg_wen_c     = 1'b0;
    take_fault    = 1'b0;

    // Counts consecutive wait cycles; any cycle without a pending wait
    // clears it, so every new request starts from zero.
    if (req_raw && !mem.mem_ready) wait_cnt_next = wait_cnt_reg + 32'd1;

    case (state_reg)
      ST_FETCH: begin
        if (timeout) take_fault = 1'b1;
        else if (handshake) begin
          ir_next    = mem.mem_rdata;
          state_next = ST_DECODE;
        end
      end
      ST_DECODE: state_next = ST_EXEC;
      ST_EXEC: begin
        if (!known_op) take_fault = 1'b1;
        else if (is_branch) begin
          if (tgt_misaligned) state_next = ST_TRAP;
          else begin
            pc_next    = br_taken ? br_tgt : pc_plus4;
            retire_c   = 1'b1;
            state_next = ST_FETCH;
          end
        end else if (is_load || is_store) begin
          addr_next  = alu_res;
          state_next = ST_MEM;
        end else if (tgt_misaligned) state_next = ST_TRAP;
        else state_next = ST_WB;
      end
      ST_MEM: begin
        if (timeout) take_fault = 1'b1;
        else if (handshake) begin
          if (is_store) begin
            pc_next    = pc_plus4;
            retire_c   = 1'b1;
            state_next = ST_FETCH;
          end else begin
            state_next = ST_WB;
          end
        end
      end
      ST_WB: begin
        reg_wen_c  = (ir_reg[11:7] != 5'd0);
        pc_next    = is_jal ? jal_tgt : (is_jalr ? jalr_tgt : pc_plus4);
        retire_c   = 1'b1;
        state_next = ST_FETCH;
      end
      ST_TRAP: begin
        illegal_c  = 1'b1;
        pc_next    = TRAP_PC;
        state_next = ST_FETCH;
      end
      default: state_next = ST_FETCH;
    endcase

    // Undefined opcode or bus timeout: trap when enabled, otherwise retire
    // the instruction as a NOP.
    if (take_fault) begin
      if (TRAP_EN) state_next = ST_TRAP;
      else begin
        pc_next    = pc_plus4;
        retire_c   = 1'b1;
        state_next = ST_FETCH;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_FETCH;
      pc_reg       <= RESET_PC;
      ir_reg       <= 32'h0;
      addr_reg     <= 32'h0;
      wait_cnt_reg <= 32'h0;
      active_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      ir_reg       <= ir_next;
      addr_reg     <= addr_next;
      wait_cnt_reg <= wait_cnt_next;
      active_reg   <= 1'b1;
    end
  end

  assign reg_wen = reg_wen_c & ~rst;
  assign retire  = retire_c & ~rst;
  assign illegal = illegal_c & ~rst;

endmodule
